// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter that owns one shared DATA_W-bit
// register. A granted requester writes its lane into the register and gets a
// one-cycle ack. If it holds lock, it may keep the grant for up to MAX_HOLD
// consecutive writes. Every grant is followed by one IDLE bubble cycle.
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [N_REQ]         level request per requester, held until served
//   lock     in   [N_REQ]         grantee asks to keep the grant for more writes
//   wdata    in   [N_REQ*DATA_W]  write data; lane i = wdata[i*DATA_W +: DATA_W]
//   gnt      out  [N_REQ]         registered grant, zero or one-hot
//   gnt_id   out  [IDW]           index of the current or most recent grantee
//   ack      out  [N_REQ]         one-cycle pulse; lane i was written
//   shared_q out  [DATA_W]        shared register contents
//   busy     out  1               high while a grant is active
module shared_reg_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4,
  localparam int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [IDW-1:0]           gnt_id,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        shared_q,
  output logic                     busy
);

  // Burst counter only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [IDW-1:0]    last;
  logic [HCW-1:0]    hold_cnt;

  logic              pick_valid_c;
  logic [IDW-1:0]    pick_idx_c;
  logic [N_REQ-1:0]  pick_oh_c;
  int unsigned       best_dist_c;
  int unsigned       dist_c;

  logic              req_g_c;
  logic              lock_g_c;
  logic [DATA_W-1:0] lane_c;
  logic              extend_c;

  // Round-robin pick: the requester closest after 'last' (with wrap) wins.
  // dist is 0 for last+1, N_REQ-1 for last itself.
  always_comb begin
    pick_valid_c = 1'b0;
    pick_idx_c   = '0;
    best_dist_c  = N_REQ;
    dist_c       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      dist_c = (i + N_REQ - 1 - 32'(last)) % N_REQ;
      if (req[i] && (dist_c < best_dist_c)) begin
        pick_valid_c = 1'b1;
        pick_idx_c   = IDW'(i);
        best_dist_c  = dist_c;
      end
    end
    pick_oh_c = pick_valid_c ? (N_REQ'(1) << pick_idx_c) : '0;
  end

  // Select the grantee's request, lock and data lane using the one-hot grant.
  always_comb begin
    req_g_c  = 1'b0;
    lock_g_c = 1'b0;
    lane_c   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        req_g_c  = req[i];
        lock_g_c = lock[i];
        lane_c   = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Burst continues only while locked and below the per-grant write limit.
  always_comb begin
    extend_c = lock_g_c && (32'(hold_cnt) < (MAX_HOLD - 1));
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ack      <= '0;
      shared_q <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last     <= IDW'(N_REQ - 1);
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (pick_valid_c) begin
            gnt      <= pick_oh_c;
            gnt_id   <= pick_idx_c;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req_g_c) begin
            // Grantee withdrew: release without writing.
            gnt   <= '0;
            last  <= gnt_id;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            shared_q <= lane_c;
            ack      <= gnt;
            if (extend_c) begin
              hold_cnt <= hold_cnt + HCW'(1);
            end else begin
              gnt   <= '0;
              last  <= gnt_id;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios with literal expectations
// plus a long random run, all compared each cycle against an ownership model.
module tb_shared_reg_arbiter;

  localparam int N     = 3;
  localparam int D     = 8;
  localparam int MH    = 4;
  localparam int IDW   = 2;
  localparam int BOUND = (N - 1) * (MH + 1) + 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*D-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   ack;
  logic [D-1:0]   shared_q;
  logic           busy;

  shared_reg_arbiter #(.N_REQ(N), .DATA_W(D), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .gnt_id(gnt_id), .ack(ack), .shared_q(shared_q), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the register (-1 = nobody), writes done in this grant,
  // who was served last, and what the outputs should read.
  int           m_owner;
  int           m_writes;
  int           m_last;
  int           m_id;
  int           m_ack;
  logic [D-1:0] m_shared;
  int           wait_c [N];

  task automatic model_reset();
    m_owner  = -1;
    m_writes = 0;
    m_last   = N - 1;
    m_id     = 0;
    m_ack    = -1;
    m_shared = '0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
  endtask

  function automatic int winner(input logic [N-1:0] r, input int from_last);
    for (int k = 1; k <= N; k++) begin
      if (r[(from_last + k) % N]) return (from_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] r;
    r     = req;
    m_ack = -1;
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner  = winner(r, m_last);
        m_id     = m_owner;
        m_writes = 0;
      end
    end else if (!r[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_shared = wdata[m_owner*D +: D];
      m_ack    = m_owner;
      m_writes++;
      if (!(lock[m_owner] && m_writes < MH)) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    // Service-time bound for every held request.
    for (int i = 0; i < N; i++) begin
      if (!r[i]) begin
        wait_c[i] = 0;
      end else begin
        wait_c[i]++;
        if (m_ack == i) begin
          chk("wait_bound", 32'(wait_c[i] <= BOUND), 32'd1);
          wait_c[i] = 0;
        end else if (wait_c[i] == BOUND + 1) begin
          chk("starved", 32'(wait_c[i]), 32'(BOUND));
        end
      end
    end
  endtask

  always @(negedge rst_n) model_reset();
  always @(posedge clk) if (rst_n) model_step();

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("gnt",      32'(gnt),      (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("gnt_id",   32'(gnt_id),   32'(m_id));
    chk("ack",      32'(ack),      (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
    chk("shared_q", 32'(shared_q), 32'(m_shared));
    chk("busy",     32'(busy),     32'(m_owner >= 0));
    chk("onehot0",  32'($onehot0(gnt)), 32'd1);
  end

  task automatic reset_dut();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [N-1:0] gq[$];
  logic [D-1:0] sq[$];
  int           ack1_cnt;
  logic [N-1:0] next_g;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single unlocked request.
    @(negedge clk);
    req   = 3'b001;
    wdata = {8'h00, 8'h00, 8'hA5};
    @(negedge clk);
    chk("t1_gnt",  32'(gnt),  32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_shared", 32'(shared_q), 32'hA5);
    chk("t1_ack",    32'(ack),      32'h1);
    chk("t1_busy0",  32'(busy),     32'h0);
    chk("t1_gnt0",   32'(gnt),      32'h0);
    req = '0;

    // All three requesting, round-robin order from reset.
    reset_dut();
    req   = 3'b111;
    wdata = {8'h33, 8'h22, 8'h11};
    repeat (8) begin
      @(negedge clk);
      if (gnt != '0) gq.push_back(gnt);
      if (ack != '0) sq.push_back(shared_q);
    end
    req = '0;
    chk("t2_ngnt", 32'(gq.size()), 32'd4);
    chk("t2_nack", 32'(sq.size()), 32'd4);
    chk("t2_g0", 32'(gq[0]), 32'h1);
    chk("t2_g1", 32'(gq[1]), 32'h2);
    chk("t2_g2", 32'(gq[2]), 32'h4);
    chk("t2_g3", 32'(gq[3]), 32'h1);
    chk("t2_s0", 32'(sq[0]), 32'h11);
    chk("t2_s1", 32'(sq[1]), 32'h22);
    chk("t2_s2", 32'(sq[2]), 32'h33);
    chk("t2_s3", 32'(sq[3]), 32'h11);

    // Locked burst on requester 1 (requester 0 was served last).
    @(negedge clk);
    req      = 3'b011;
    lock     = 3'b010;
    wdata    = {8'h00, 8'h5C, 8'h01};
    ack1_cnt = 0;
    next_g   = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ack == 3'b010) begin
        ack1_cnt++;
        chk("t3_shared", 32'(shared_q), 32'h5C);
      end
      if (ack1_cnt == MH && ack == '0 && gnt != '0) begin
        next_g = gnt;
        break;
      end
    end
    chk("t3_acks",  32'(ack1_cnt), 32'd4);
    chk("t3_nextg", 32'(next_g),   32'h1);
    req  = '0;
    lock = '0;

    // Grantee drops its request before the write edge.
    reset_dut();
    req   = 3'b100;
    wdata = {8'h77, 8'h00, 8'h00};
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'h4);
    req = '0;
    @(negedge clk);
    chk("t4_ack",    32'(ack),      32'h0);
    chk("t4_shared", 32'(shared_q), 32'h0);
    chk("t4_busy",   32'(busy),     32'h0);

    // Asynchronous reset in the middle of a locked burst.
    reset_dut();
    req   = 3'b001;
    lock  = 3'b001;
    wdata = {8'h00, 8'h00, 8'h3C};
    @(negedge clk);
    @(negedge clk);
    chk("t5_pre_ack", 32'(ack), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_gnt",    32'(gnt),      32'h0);
    chk("t5_ack",    32'(ack),      32'h0);
    chk("t5_shared", 32'(shared_q), 32'h0);
    chk("t5_busy",   32'(busy),     32'h0);
    chk("t5_gnt_id", 32'(gnt_id),   32'h0);
    req  = 3'b110;
    lock = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first",    32'(gnt),    32'h2);
    chk("t5_first_id", 32'(gnt_id), 32'h1);
    req = '0;
    repeat (3) @(negedge clk);

    // Random traffic: requests held until acked, then maybe released.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      lock  = N'($urandom);
      wdata = (N*D)'($urandom);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_ack == i) req[i] = 1'($urandom_range(0, 1));
        end else begin
          req[i] = ($urandom_range(0, 2) == 0);
        end
      end
    end
    req  = '0;
    lock = '0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
